// File: rtl/buf_arb_pkg.sv
// Shared types and helpers for the buffer-stage arbiter: FSM state encoding,
// width helpers and the one-hot grant encoder.
package buf_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Upper bound on requester count supported by the one-hot encoder.
  localparam int MAX_REQ   = 64;
  localparam int MAX_SRC_W = 6;

  function automatic int cnt_w(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

  function automatic int src_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_SRC_W-1:0] idx);
    logic [MAX_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/buf_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from ptr+1 with wrap-around.
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SRC_W = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] winner,
  output logic             any
);

  logic [SRC_W-1:0] idx;

  // Scan from the farthest candidate down so the nearest one after ptr wins;
  // N_REQ is a power of two, so the index add wraps naturally.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ptr + SRC_W'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buf_arbiter.sv
// Round-robin arbiter and sequencer for the shared 1-bit registered buffer
// stage: grants non-preemptive bursts and registers the winner's serial bits.
module buf_arbiter
  import buf_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BURST = 8,
  localparam int SRC_W = src_w(N_REQ),
  localparam int CNT_W = cnt_w(BURST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  output logic [N_REQ-1:0] gnt,
  output logic             out,
  output logic             out_valid,
  output logic [SRC_W-1:0] out_src,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] src;
  logic [SRC_W-1:0] win;
  logic             any;
  logic             last_slot;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .any    (any)
  );

  assign last_slot = (cnt == CNT_W'(BURST - 1));
  assign busy      = (state == XFER);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= SRC_W'(N_REQ - 1);
      src       <= '0;
      gnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      out_src   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          if (any) begin
            state <= XFER;
            src   <= win;
            cnt   <= '0;
            gnt   <= N_REQ'(onehot(MAX_SRC_W'(win)));
          end
        end
        XFER: begin
          // Output register stage: one-cycle lag behind the granted slot.
          out       <= in[src];
          out_valid <= 1'b1;
          out_src   <= src;
          if (last_slot) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= src;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buf_arbiter.sv
// Self-checking bench for buf_arbiter: table-driven grant vectors, a serial-bit
// scoreboard, and hand-written rotation / reset-abort sequences.
module tb_buf_arbiter;
  localparam int N_REQ = 4;
  localparam int BURST = 8;
  localparam int SRC_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] in = '0;
  logic [N_REQ-1:0] gnt;
  logic             out;
  logic             out_valid;
  logic [SRC_W-1:0] out_src;
  logic             busy;

  buf_arbiter #(.N_REQ(N_REQ), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (in),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             bit_v;
    logic [SRC_W-1:0] src;
  } exp_t;

  typedef struct {
    logic [N_REQ-1:0] req;
    int               drop;
    int               exp_win;
    string            name;
  } vec_t;

  exp_t       sb[$];
  int         rise_src[$];
  int         rise_cyc[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;
  int         len = 0;
  logic [N_REQ-1:0] gnt_prev = '0;
  logic [BURST-1:0] pat [N_REQ];

  function automatic int idx_of(input logic [N_REQ-1:0] g);
    for (int i = 0; i < N_REQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Requester model + output scoreboard, all on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    logic b;
    cycle++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: out_valid=1 with nothing expected (cycle %0d)", cycle);
      end else begin
        e = sb.pop_front();
        check("out_bit", 32'(out), 32'(e.bit_v));
        check("out_src", 32'(out_src), 32'(e.src));
      end
    end else begin
      check("out_zero_when_invalid", 32'(out), 32'd0);
    end
    check("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);

    if (!rst_n) begin
      sb.delete();
      len      = 0;
      gnt_prev = '0;
      in       = '0;
    end else begin
      if (gnt == '0 && gnt_prev != '0) check("burst_len", 32'(len), 32'(BURST));
      if (gnt != '0 && gnt_prev == '0) begin
        len = 0;
        rise_src.push_back(idx_of(gnt));
        rise_cyc.push_back(cycle);
      end
      in = N_REQ'($urandom);
      if (gnt != '0) begin
        s = idx_of(gnt);
        b = (len < BURST) ? pat[s][BURST-1-len] : 1'b0;
        in[s] = b;
        sb.push_back({b, SRC_W'(s)});
        len++;
      end
      gnt_prev = gnt;
    end
  end

  task automatic wait_gnt(input bit want, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((gnt != '0) == want) begin
        ok = 1'b1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for gnt %s, got %b", name, want ? "high" : "low", gnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    bit   ok;
    int   exp_order[5];

    pat[0] = 8'b1011_0011;
    pat[1] = 8'hA5;
    pat[2] = 8'h3C;
    pat[3] = 8'hE1;

    vecs[0] = '{req: 4'b0001, drop: 0, exp_win: 0, name: "single_req0"};
    vecs[1] = '{req: 4'b0010, drop: 0, exp_win: 1, name: "single_req1"};
    vecs[2] = '{req: 4'b0110, drop: 0, exp_win: 2, name: "rot_req2"};
    vecs[3] = '{req: 4'b0110, drop: 0, exp_win: 1, name: "rot_req1"};
    vecs[4] = '{req: 4'b1000, drop: 2, exp_win: 3, name: "drop_req3"};
    exp_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    repeat (20) begin
      @(negedge clk);
      check("idle_quiet", 32'({gnt, busy, out, out_valid}), 32'd0);
    end

    foreach (vecs[v]) begin
      req = vecs[v].req;
      wait_gnt(1'b1, vecs[v].name, ok);
      if (ok) check(vecs[v].name, 32'(idx_of(gnt)), 32'(vecs[v].exp_win));
      if (vecs[v].drop > 0) begin
        repeat (vecs[v].drop) @(negedge clk);
        req = '0;
      end
      wait_gnt(1'b0, vecs[v].name, ok);
      req = '0;
      repeat (2) @(negedge clk);
    end

    // All requesters continuously asserted: strict rotation with one-cycle gaps.
    rise_src.delete();
    rise_cyc.delete();
    req = 4'b1111;
    for (int i = 0; i < 80 && rise_src.size() < 5; i++) @(negedge clk);
    req = '0;
    check("all_req_grants", 32'(rise_src.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < rise_src.size(); i++) begin
      check("all_req_order", 32'(rise_src[i]), 32'(exp_order[i]));
      if (i > 0) check("all_req_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'(BURST + 1));
    end
    wait_gnt(1'b0, "all_req_end", ok);
    repeat (2) @(negedge clk);

    // Reset during the 4th cycle of a req2 burst aborts it immediately.
    req = 4'b0100;
    wait_gnt(1'b1, "abort_req2", ok);
    if (ok) check("abort_win", 32'(idx_of(gnt)), 32'd2);
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(1'b1, "post_reset", ok);
    if (ok) check("post_reset_win", 32'(idx_of(gnt)), 32'd0);
    req = '0;
    wait_gnt(1'b0, "post_reset_end", ok);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
